// File: rtl/rv32m_fused_mdu_if.sv
// rv32m_fused_mdu_if: issue/result bundle between EX control and the fused multiply/divide unit.
interface rv32m_fused_mdu_if;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] a;
  logic [31:0] b;
  logic        fuse;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        fused_hit;
  modport master (output start, func3, a, b, fuse, flush, input busy, done, result, fused_hit);
  modport slave  (input start, func3, a, b, fuse, flush, output busy, done, result, fused_hit);
endinterface

// File: rtl/rv32m_fused_mdu.sv
// rv32m_fused_mdu: iterative RV32M multiply/divide that buffers the companion result
// (low product word or quotient/remainder) so a fused follow-up op completes in one cycle.
module rv32m_fused_mdu #(
  parameter int XLEN = 32,
  parameter int MUL_STAGES = 2
) (
  input logic clk,
  input logic clrn,
  rv32m_fused_mdu_if.slave m
);
  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DIV_FIX} state_t;
  state_t state;
  logic [2:0] f3;
  logic [XLEN-1:0] op_a, op_b, dvs, quo, rem, buf_data, q_fix, r_fix;
  logic [4:0] cnt;
  logic buf_valid, buf_div, buf_sgn, neg_q, neg_r;
  logic hit, a_neg, b_neg, a_sgn, b_sgn, dz, ovf;
  logic [63:0] prod;
  logic [32:0] r_sh, diff;
  always_comb begin
    hit = m.fuse && buf_valid &&
          (m.func3 == 3'b000 ? !buf_div : m.func3[2] && buf_div && buf_sgn == m.func3[0]);
    a_neg = !m.func3[0] && m.a[31];
    b_neg = !m.func3[0] && m.b[31];
    a_sgn = f3 == 3'b001 || f3 == 3'b010;
    b_sgn = f3 == 3'b001;
    prod = {{32{a_sgn && op_a[31]}}, op_a} * {{32{b_sgn && op_b[31]}}, op_b};
    r_sh = {rem, quo[31]};
    diff = r_sh - {1'b0, dvs};
    dz = op_b == '0;
    ovf = !f3[0] && op_a == 32'h8000_0000 && op_b == '1;
    q_fix = dz ? '1 : ovf ? 32'h8000_0000 : neg_q ? -quo : quo;
    r_fix = dz ? op_a : ovf ? '0 : neg_r ? -rem : rem;
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      m.busy <= 1'b0;
      m.done <= 1'b0;
      m.fused_hit <= 1'b0;
      m.result <= '0;
      buf_valid <= 1'b0;
      buf_data <= '0;
      buf_div <= 1'b0;
      buf_sgn <= 1'b0;
      f3 <= '0;
      op_a <= '0;
      op_b <= '0;
      dvs <= '0;
      quo <= '0;
      rem <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      m.done <= 1'b0;
      m.fused_hit <= 1'b0;
      if (m.flush) begin
        state <= IDLE;
        m.busy <= 1'b0;
        buf_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (m.start) begin
            if (hit) begin
              m.result <= buf_data;
              m.done <= 1'b1;
              m.fused_hit <= 1'b1;
            end else begin
              // divider operands are loaded as magnitudes; signs are restored in DIV_FIX
              f3 <= m.func3;
              op_a <= m.a;
              op_b <= m.b;
              dvs <= b_neg ? -m.b : m.b;
              quo <= a_neg ? -m.a : m.a;
              rem <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt <= '0;
              buf_valid <= 1'b0;
              m.busy <= 1'b1;
              state <= m.func3[2] ? DIV_BUSY : MUL_BUSY;
            end
          end
          MUL_BUSY: begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'(MUL_STAGES - 1)) begin
              state <= IDLE;
              m.busy <= 1'b0;
              m.done <= 1'b1;
              m.result <= f3[1:0] == 2'b00 ? prod[31:0] : prod[63:32];
              buf_data <= prod[31:0];
              buf_valid <= f3[1:0] != 2'b00;
              buf_div <= 1'b0;
            end
          end
          DIV_BUSY: begin
            cnt <= cnt + 5'd1;
            rem <= diff[32] ? r_sh[31:0] : diff[31:0];
            quo <= {quo[30:0], !diff[32]};
            if (cnt == 5'd31) state <= DIV_FIX;
          end
          DIV_FIX: begin
            state <= IDLE;
            m.busy <= 1'b0;
            m.done <= 1'b1;
            m.result <= f3[1] ? r_fix : q_fix;
            buf_data <= f3[1] ? q_fix : r_fix;
            buf_valid <= 1'b1;
            buf_div <= 1'b1;
            buf_sgn <= f3[0];
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rv32m_fused_mdu.sv
// tb_rv32m_fused_mdu: vector table plus hand sequences for flush, reset and busy-start corners.
module tb_rv32m_fused_mdu;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;
  rv32m_fused_mdu_if bus ();
  rv32m_fused_mdu #(.XLEN(32), .MUL_STAGES(2)) dut (.clk(clk), .clrn(clrn), .m(bus));
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        fuse;
    logic [31:0] res;
    logic        hit;
    int          lat;
  } vec_t;
  typedef struct {
    logic [31:0] res;
    logic        hit;
    int          lat;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[18];
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic fuse, input exp_t e_in, input int poke, input string tag);
    exp_t e;
    int lat;
    bus.start = 1'b1;
    bus.func3 = f3;
    bus.a = a;
    bus.b = b;
    bus.fuse = fuse;
    sb.push_back(e_in);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.fuse = 1'b0;
    lat = 1;
    if (e_in.lat > 1) chk({tag, "_busy_run"}, {31'b0, bus.busy}, 32'd1);
    while (bus.done !== 1'b1 && lat < 60) begin
      if (lat == poke) begin
        bus.start = 1'b1;
        bus.func3 = 3'b000;
        bus.a = 32'h0000_dead;
        bus.b = 32'h0000_beef;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_res"}, bus.result, e.res);
    chk({tag, "_hit"}, {31'b0, bus.fused_hit}, {31'b0, e.hit});
    chk({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd0);
  endtask
  initial begin
    int seen;
    tbl[0]  = '{3'b001, 32'h8000_0000, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 1'b0, 3};
    tbl[1]  = '{3'b000, 32'h8000_0000, 32'h0000_0002, 1'b1, 32'h0000_0000, 1'b1, 1};
    tbl[2]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFD, 1'b0, 34};
    tbl[3]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 1'b1, 1};
    tbl[4]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 34};
    tbl[5]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0005, 1'b1, 1};
    tbl[6]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 34};
    tbl[7]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1};
    tbl[8]  = '{3'b101, 32'd100,       32'd7,         1'b0, 32'd14,        1'b0, 34};
    tbl[9]  = '{3'b110, 32'd100,       32'd7,         1'b1, 32'd2,         1'b0, 34};
    tbl[10] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 3};
    tbl[11] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b1, 1};
    tbl[12] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 3};
    tbl[13] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 1'b0, 32'h2345_6780, 1'b0, 3};
    tbl[14] = '{3'b111, 32'd7,         32'd3,         1'b1, 32'd1,         1'b0, 34};
    tbl[15] = '{3'b101, 32'd7,         32'd3,         1'b1, 32'd2,         1'b1, 1};
    tbl[16] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 1'b0, 34};
    tbl[17] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 1'b1, 32'd1,         1'b1, 1};
    bus.start = 1'b0;
    bus.func3 = 3'b000;
    bus.a = '0;
    bus.b = '0;
    bus.fuse = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_hit", {31'b0, bus.fused_hit}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++)
      run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].fuse,
             '{tbl[i].res, tbl[i].hit, tbl[i].lat}, -1, $sformatf("v%0d", i));
    // flush in idle drops the buffered low word
    run_op(3'b011, 32'd2, 32'd3, 1'b0, '{32'd0, 1'b0, 3}, -1, "mulhu");
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", {31'b0, bus.busy}, 32'd0);
    run_op(3'b000, 32'd2, 32'd3, 1'b1, '{32'd6, 1'b0, 3}, -1, "mul_after_flush");
    // flush mid-divide, then flush coinciding with start
    bus.start = 1'b1;
    bus.func3 = 3'b101;
    bus.a = 32'd9;
    bus.b = 32'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_mid_busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    chk("flush_start_dropped", {31'b0, bus.busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1;
    end
    chk("flush_no_done", seen, 32'd0);
    // asynchronous reset at divide iteration 15
    run_op(3'b001, 32'd3, 32'd5, 1'b0, '{32'd0, 1'b0, 3}, -1, "mulh");
    bus.start = 1'b1;
    bus.func3 = 3'b100;
    bus.a = 32'd100;
    bus.b = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_busy_after", {31'b0, bus.busy}, 32'd0);
    run_op(3'b000, 32'd3, 32'd5, 1'b1, '{32'd15, 1'b0, 3}, -1, "mul_after_rst");
    // start while busy is ignored
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0, '{32'hFFFF_FFFD, 1'b0, 34}, 10, "div_poke");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv32m_fused_mdu.md
Name: rv32m_fused_mdu

Overview:
Iterative RV32M multiply/divide execution unit that consumes the `fuse` indication from the decode-side fusion detector. On every computed op it keeps the companion result: the low product word after MULH/MULHSU/MULHU, and the remainder or quotient after DIV[U]/REM[U]. A following fused op (MUL after MULH*, REM[U] after DIV[U], or DIV[U] after REM[U]) returns the buffered value in one cycle without recomputing. Sits in EX, beside the ALU; busy stalls the pipeline.

Parameters:
XLEN, 32, operand/result width (only 32 supported).
MUL_STAGES, 2, cycles spent in MUL_BUSY for any multiply (at least 1).

Ports:
clk  input  1  clock, rising edge.
clrn  input  1  asynchronous active-low reset.
start  input  1  issue pulse; sampled only when busy=0.
func3  input  3  RV32M func3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
a  input  32  rs1 value.
b  input  32  rs2 value.
fuse  input  1  from fusion detector: this op pairs with the previous M op on the same rs1/rs2.
flush  input  1  pipeline/interrupt flush; aborts the current op and invalidates the buffer.
busy  output  1  op in progress.
done  output  1  one-cycle pulse; result valid.
result  output  32  op result; held from done until the next accepted start.
fused_hit  output  1  pulses together with done when the op was served from the buffer.

Behaviour:
- Reset (clrn=0, asynchronous): state IDLE; busy=0, done=0, fused_hit=0, result=0; buffer valid bit cleared, buffer data 0.
- States: IDLE, MUL_BUSY, DIV_BUSY, DIV_FIX.
- Accept: in IDLE with start=1 and flush=0, latch func3/a/b. A start while busy=1 is ignored.
- Fused path: taken when start, fuse and buf_valid are all 1 and the buffer kind matches:
  - MUL needs buf_kind=MUL.
  - REM[U] or DIV[U] needs buf_kind=DIV with the same signedness (func3[0] equal).
  - On the next edge: result=buffer, done=1, fused_hit=1. State stays IDLE. Buffer is unchanged and stays valid.
  - fuse=1 without a match falls back to the full computation, with fused_hit=0.
- Multiply:
  - Full 64-bit product. Signedness: MULH s×s, MULHSU s×u, MULHU and MUL u×u.
  - Stay MUL_BUSY_STAGES cycles, then done. Latency from the start edge to the done cycle is MUL_STAGES+1.
  - MUL returns the low word and buffers nothing (buf_valid cleared).
  - MULH* returns the high word and buffers the low word, with kind=MUL and buf_valid=1.
- Divide:
  - Operands are converted to magnitudes when signed.
  - Restoring radix-2, 32 iterations in DIV_BUSY; a 5-bit counter runs 0..31.
  - DIV_FIX applies signs: quotient negative iff the signs differ; remainder takes the dividend's sign.
  - done is asserted in the cycle after DIV_FIX; total latency is 34.
  - Returns the quotient (DIV/DIVU) or the remainder (REM/REMU). The other value is buffered with kind=DIV, signedness=func3[0], buf_valid=1.
- Special cases, resolved in DIV_FIX (the iteration result is discarded):
  - b=0: quotient 0xFFFFFFFF, remainder a, for both signed and unsigned.
  - Signed a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- flush=1 in any state:
  - Next edge returns to IDLE with busy=0, done=0 and buf_valid=0.
  - If flush and start coincide, start is dropped.
- A new non-fused op overwrites the buffer at its completion. buf_valid is cleared at acceptance, so an aborted op never leaves a stale pair.
- busy=1 from the edge after accept until the edge that raises done; it is 0 in the done cycle. Back-to-back start is allowed in the done cycle.

Test Plan:
- MULH a=0x80000000, b=0x00000002 → result 0xFFFFFFFF after MUL_STAGES+1 cycles. Then MUL with fuse=1 → 0x00000000 one cycle after start, fused_hit=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD after 34 cycles. Fused REM → 0xFFFFFFFF in 1 cycle.
- DIVU a=5, b=0 → 0xFFFFFFFF; fused REMU → 0x00000005. DIV 0x80000000/0xFFFFFFFF → 0x80000000; fused REM → 0.
- DIVU 100/7 = 14, then REM (signed) with fuse=1 → signedness mismatch; full 34-cycle recompute → 2, fused_hit=0.
- Each of the following causes a subsequent fused MUL to recompute (not 1-cycle), and busy stays 0 after the flush/reset:
  - MULHU, then flush, then MUL with fuse=1.
  - clrn pulsed low at DIV iteration 15.
- start while busy at DIV iteration 10 → ignored; the original DIV result is delivered unchanged at cycle 34.
